// File: rtl/capsense_i2c_target.sv
// rtl/capsense_i2c_target.sv - I2C target emulating the CapSense controller register interface
module capsense_i2c_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h28,
    parameter logic [7:0] PRODUCT_ID = 8'h6D,
    parameter logic [7:0] MFR_ID     = 8'h5D
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] button_status,
    output logic [7:0] ctrl_reg,
    output logic       wr_strobe,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, sda_sync_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        busy_q, busy_d;

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] load_ptr, rd_byte;

    // Synchronizers reset to the idle-high bus level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_in};
            sda_sync_q <= {sda_sync_q[1:0], sda_in};
        end
    end

    assign scl_s      = scl_sync_q[1];
    assign scl_h      = scl_sync_q[2];
    assign sda_s      = sda_sync_q[1];
    assign sda_h      = sda_sync_q[2];
    assign scl_rise   = scl_s & ~scl_h;
    assign scl_fall   = ~scl_s & scl_h;
    assign start_cond = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_cond  = scl_s & scl_h & ~sda_h & sda_s;

    // The master-ACK reload fetches the byte after the current pointer.
    assign load_ptr = (state_q == RD_MACK) ? ptr_q + 8'd1 : ptr_q;

    always_comb begin
        case (load_ptr)
            8'h00:   rd_byte = ctrl_q;
            8'h03:   rd_byte = button_status;
            8'hFD:   rd_byte = PRODUCT_ID;
            8'hFE:   rd_byte = MFR_ID;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        ctrl_d      = ctrl_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        busy_d      = busy_q;
        if (start_cond) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_cond) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        rx_d  = {rx_q[6:0], sda_s};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ADDR) begin
                            if (rx_q[7:1] == DEV_ADDR) begin
                                busy_d  = 1'b1;
                                state_d = ADDR_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = WAIT_STOP;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d   = rx_q;
                            state_d = PTR_ACK;
                        end else begin
                            if (ptr_q == 8'h00) ctrl_d = rx_q;
                            wr_strobe_d = 1'b1;
                            ptr_d       = ptr_q + 8'd1;
                            state_d     = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rx_q[0]) begin
                            tx_d     = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            cnt_d    = 4'd1;
                            state_d  = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = PTR;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_MACK;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                RD_MACK: begin
                    // A falling edge here always follows an ACKed rising edge; NACK exits on the rise.
                    if (scl_rise && sda_s) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall) begin
                        ptr_d    = ptr_q + 8'd1;
                        tx_d     = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        cnt_d    = 4'd1;
                        state_d  = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            ctrl_q      <= 8'h00;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            ctrl_q      <= ctrl_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign ctrl_reg  = ctrl_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_capsense_i2c_target.sv
// tb/tb_capsense_i2c_target.sv - transaction-level bench for capsense_i2c_target
module tb_capsense_i2c_target;
    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] button_status = 8'h00;
    logic       sda_oe;
    logic [7:0] ctrl_reg;
    logic       wr_strobe;
    logic       busy;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    capsense_i2c_target dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .scl_in        (scl_m),
        .sda_in        (sda_line),
        .sda_oe        (sda_oe),
        .button_status (button_status),
        .ctrl_reg      (ctrl_reg),
        .wr_strobe     (wr_strobe),
        .busy          (busy)
    );

    int checks = 0;
    int failures = 0;
    int oe_cnt = 0;
    int strobe_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (wr_strobe) strobe_cnt++;
        if (busy) busy_cnt++;
    end

    logic [7:0] m_ctrl = 8'h00;
    logic [7:0] m_ptr = 8'h00;

    function automatic logic [7:0] m_reg(input logic [7:0] a);
        if (a == 8'h00) return m_ctrl;
        if (a == 8'h03) return button_status;
        if (a == 8'hFD) return 8'h6D;
        if (a == 8'hFE) return 8'h5D;
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic do_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic do_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq(); wq();
    endtask

    task automatic send(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wq();
            scl_m = 1'b1; wq(); wq();
            scl_m = 1'b0; wq();
        end
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        ack = ~sda_line;
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic recv(input logic nack, input logic chg, input logic [7:0] newb,
                        output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
            b[i] = sda_line;
            if (chg && i == 4) button_status = newb;
            wq();
            scl_m = 1'b0; wq();
        end
        sda_m = nack; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
        sda_m = 1'b1;
    endtask

    task automatic wr_txn(input logic [7:0] ptr, input int n, input logic [7:0] d0);
        logic ack;
        logic [7:0] d;
        int s0;
        do_start();
        send(8'h50, ack); chk("wr_addr_ack", ack, 1'b1);
        chk("busy_after_match", busy, 1'b1);
        send(ptr, ack); chk("wr_ptr_ack", ack, 1'b1);
        m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : 8'($urandom);
            s0 = strobe_cnt;
            send(d, ack); chk("wr_data_ack", ack, 1'b1);
            chk("wr_strobe_pulses", strobe_cnt - s0, 1);
            if (m_ptr == 8'h00) m_ctrl = d;
            m_ptr = m_ptr + 8'd1;
        end
        do_stop();
        chk("busy_after_stop", busy, 1'b0);
        chk("ctrl_reg", ctrl_reg, m_ctrl);
    endtask

    task automatic rd_txn(input logic set_ptr, input logic [7:0] ptr, input int n,
                          input logic chg, input logic [7:0] newb);
        logic ack;
        logic [7:0] b, e;
        do_start();
        if (set_ptr) begin
            send(8'h50, ack); chk("rd_waddr_ack", ack, 1'b1);
            send(ptr, ack); chk("rd_ptr_ack", ack, 1'b1);
            m_ptr = ptr;
            do_start();
        end
        send(8'h51, ack); chk("rd_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            e = m_reg(m_ptr);
            recv(i == n - 1, chg && i == 0, newb, b);
            chk("rd_data", b, e);
            if (i != n - 1) m_ptr = m_ptr + 8'd1;
        end
        chk("sda_released_after_nack", sda_oe, 1'b0);
        do_stop();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic [7:0] ptrs [6];
        int o0, b0;
        ptrs = '{8'h00, 8'h03, 8'hFD, 8'hFE, 8'hFF, 8'h10};

        repeat (4) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_ctrl_reg", ctrl_reg, 8'h00);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        wq();

        wr_txn(8'h00, 1, 8'hA5);
        chk("ctrl_A5", ctrl_reg, 8'hA5);
        rd_txn(1'b0, 8'h00, 1, 1'b0, 8'h00);
        chk("ptr_after_write", m_ptr, 8'h01);

        rd_txn(1'b1, 8'hFD, 2, 1'b0, 8'h00);

        button_status = 8'h02;
        rd_txn(1'b1, 8'h03, 1, 1'b1, 8'h01);
        chk("btn_changed_after", button_status, 8'h01);

        o0 = oe_cnt; b0 = busy_cnt;
        do_start();
        send(8'h52, ack); chk("mismatch_nack", ack, 1'b0);
        send(8'h00, ack); send(8'hFF, ack);
        chk("mismatch_no_drive", oe_cnt - o0, 0);
        chk("mismatch_no_busy", busy_cnt - b0, 0);
        do_stop();
        chk("mismatch_ctrl_kept", ctrl_reg, m_ctrl);

        wr_txn(8'hFF, 2, 8'h77);
        chk("wrap_ctrl_second", ctrl_reg, m_ctrl);

        for (int it = 0; it < 16; it++) begin
            button_status = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                wr_txn(ptrs[$urandom_range(0, 5)], $urandom_range(1, 3), 8'($urandom));
            else
                rd_txn(1'($urandom_range(0, 1)), ptrs[$urandom_range(0, 5)],
                       $urandom_range(1, 3), 1'b0, 8'h00);
        end

        wr_txn(8'h00, 1, 8'h3C);
        do_start();
        send(8'h50, ack); send(8'h00, ack);
        do_start();
        send(8'h51, ack); chk("rst_rd_ack", ack, 1'b1);
        chk("rd_bit7_driving_low", sda_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_release", sda_oe, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_ctrl = 8'h00; m_ptr = 8'h00;
        chk("ctrl_after_reset", ctrl_reg, 8'h00);
        o0 = oe_cnt;
        send(8'h50, ack); chk("ignored_addr_after_reset", ack, 1'b0);
        send(8'h00, ack);
        chk("no_drive_after_reset", oe_cnt - o0, 0);
        rd_txn(1'b1, 8'hFD, 1, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/capsense_i2c_target.md
Name: capsense_i2c_target

Overview:
- I2C target (responder) emulating the capacitive-sense controller at the far end of the board's CapSense I2C bus.
- Presents button status and ID registers to an I2C initiator.
- Used as the bus model in system simulation and as an FPGA-side stand-in when the sense chip is absent.
- Oversamples SCL/SDA on the 50 MHz system clock and drives SDA open-drain only.

Parameters:
- DEV_ADDR, 7'h28, 7-bit target address matched after START.
- PRODUCT_ID, 8'h6D, value returned at register 0xFD.
- MFR_ID, 8'h5D, value returned at register 0xFE.

Ports:
- clk  input  1  50 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- scl_in  input  1  raw SCL from pad.
- sda_in  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pull SDA low, 0 = release. Pad drives 0 when set, Z otherwise.
- button_status  input  8  live sensor input bits; bit0 = button_0, bit1 = button_1.
- ctrl_reg  output  8  register 0x00 contents.
- wr_strobe  output  1  one-cycle pulse on each accepted data-byte write.
- busy  output  1  high from matched address ACK until STOP or START.

Behaviour:
- Reset values: sda_oe=0, ctrl_reg=0x00, wr_strobe=0, busy=0, pointer=0x00, state=IDLE.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer plus one history FF.
  - Edges are detected on synchronized values.
  - Total input latency is 3 clk.
- Bus conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are detected in any state and take priority over bit processing in the same cycle.
- Timing rules:
  - Data is sampled on SCL rising edge.
  - sda_oe changes only on the cycle after an SCL falling edge is detected.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP.
- IDLE:
  - START -> ADDR, bit counter = 0.
- ADDR:
  - Shift 8 bits, MSB first.
  - On the 8th falling edge: if bits[7:1]==DEV_ADDR, assert sda_oe and go to ADDR_ACK.
  - On mismatch, go to WAIT_STOP with sda_oe=0 (NACK).
- ADDR_ACK:
  - On the following falling edge, release SDA.
  - R/W=0 -> PTR. R/W=1 -> RDATA, with the shift register loaded from the register at pointer.
  - In RDATA, bit7 drives on that same falling edge: sda_oe = ~bit.
- PTR:
  - 8 bits -> pointer.
  - ACK in PTR_ACK, then WDATA.
- WDATA:
  - 8 bits received; ACK in WDATA_ACK.
  - If pointer==0x00, update ctrl_reg. Other addresses ignore the write but are still ACKed.
  - wr_strobe pulses on the ACK falling edge for every byte.
  - pointer += 1, wrapping 0xFF -> 0x00.
- RDATA:
  - Drive 8 bits; release after bit0's falling edge.
  - In RD_MACK, sample the initiator's ACK on SCL rising.
  - ACK (0): pointer += 1, load next byte, and return to RDATA.
  - NACK (1): go to WAIT_STOP with SDA released.
- Register map (read):
  - 0x00 = ctrl_reg.
  - 0x03 = button_status, captured at the cycle the byte is loaded, so bits are stable for the whole byte.
  - 0xFD = PRODUCT_ID.
  - 0xFE = MFR_ID.
  - All others = 0x00.
- Repeated START in any state:
  - Release SDA, go to ADDR, keep the pointer.
  - This supports write-pointer-then-read.
- STOP in any state: release SDA, go to IDLE, busy=0. The pointer is retained.
- Reset mid-transaction: sda_oe drops to 0 asynchronously; the block ignores the bus until the next START.
- Glitches shorter than 2 clk on SCL/SDA are not filtered beyond synchronization. Standard/Fast mode (≤400 kHz) is guaranteed.

Test Plan:
- Write [0x50,0x00,0xA5] + STOP -> three ACKs, ctrl_reg=0xA5, one wr_strobe pulse for the data byte, pointer ends at 0x01.
- Write 0x50,0xFD, repeated START, read 0x51, two bytes ACK then NACK, STOP -> reads 0x6D then 0x5D; SDA released after NACK.
- button_status=0x02; write pointer 0x03, repeated START, read one byte -> 0x02.
  - Change button_status to 0x01 mid-byte -> byte still reads 0x02.
- Address 0x52 (mismatch) -> NACK (SDA high on 9th clock), no further SDA drive until STOP, busy stays 0, ctrl_reg unchanged.
- Pointer 0xFF, write two data bytes -> both ACKed, second targets 0x00, ctrl_reg = second byte.
- Assert reset_n=0 while the target drives a 0 read bit -> sda_oe=0 within the same cycle; after release, the next bytes are ignored until a fresh START.
